// File: rtl/dcache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned TAG_W    = 22;
  localparam int unsigned INDEX_W  = 5;
  localparam int unsigned WORD_W   = 3;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned LINES    = 32;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and line storage: one asynchronous read port, one synchronous write port.
// Only valid/dirty are reset; tags and data come up undefined.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [LINE_W-1:0]  rd_data,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_dirty,
  input  logic [LINE_W-1:0]  wr_data
);

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [LINE_W-1:0] lines [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (we) begin
      valid[wr_index] <= 1'b1;
      dirty[wr_index] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_data;
    end
  end

  assign rd_tag   = tags[rd_index];
  assign rd_valid = valid[rd_index];
  assign rd_dirty = dirty[rd_index];
  assign rd_data  = lines[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller (32 x 32-byte lines).
// Define DCACHE_STATS_EN to add saturating hit_cnt_o / miss_cnt_o counters.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   p1_addr_i,
  input  logic [31:0]   p1_data_i,
  input  logic          p1_MemRead_i,
  input  logic          p1_MemWrite_i,
  output logic [31:0]   p1_data_o,
  output logic          p1_stall_o,
  output logic [31:0]   mem_addr_o,
  output logic [255:0]  mem_data_o,
  output logic          mem_enable_o,
  output logic          mem_write_o,
  input  logic [255:0]  mem_data_i,
  input  logic          mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]   hit_cnt_o,
  output logic [31:0]   miss_cnt_o
`endif
);

  state_t              state;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  idx;
  logic [WORD_W-1:0]   word;
  logic                active;
  logic                hit;
  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;
  logic                rd_dirty;
  logic [LINE_W-1:0]   rd_data;
  logic [LINE_W-1:0]   hit_line;
  logic                we;
  logic                unused;

  assign req_tag = p1_addr_i[31:10];
  assign idx     = p1_addr_i[9:5];
  assign word    = p1_addr_i[4:2];
  assign unused  = ^p1_addr_i[1:0];

  assign active     = p1_MemRead_i | p1_MemWrite_i;
  assign hit        = active && rd_valid && (rd_tag == req_tag);
  assign p1_stall_o = (active && !hit) || (state != IDLE);
  assign p1_data_o  = hit ? rd_data[{word, 5'b0} +: 32] : '0;
  assign mem_data_o = (state == WRITEBACK) ? rd_data : '0;

  always_comb begin
    hit_line = rd_data;
    hit_line[{word, 5'b0} +: 32] = p1_data_i;
  end

  // Store hits are only committed in IDLE; the refill write is the only other writer.
  assign we = ((state == IDLE) && hit && p1_MemWrite_i) ||
              ((state == READMISS) && mem_ack_i);

  dcache_sram u_sram (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .rd_index (idx),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_data  (rd_data),
    .we       (we),
    .wr_index (idx),
    .wr_tag   (req_tag),
    .wr_dirty (state == IDLE),
    .wr_data  ((state == READMISS) ? mem_data_i : hit_line)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
    end else begin
      case (state)
        IDLE: if (active && !hit) state <= MISS;
        MISS: begin
          mem_enable_o <= 1'b1;
          if (rd_valid && rd_dirty) begin
            state       <= WRITEBACK;
            mem_write_o <= 1'b1;
            mem_addr_o  <= {rd_tag, idx, {OFFSET_W{1'b0}}};
          end else begin
            state       <= READMISS;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {req_tag, idx, {OFFSET_W{1'b0}}};
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          state       <= READMISS;
          mem_write_o <= 1'b0;
          mem_addr_o  <= {req_tag, idx, {OFFSET_W{1'b0}}};
        end
        READMISS: if (mem_ack_i) begin
          state        <= READMISSOK;
          mem_enable_o <= 1'b0;
          mem_addr_o   <= '0;
        end
        READMISSOK: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic just_filled;

  // The replayed request right after a refill is the tail of a miss, not a new hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o   <= '0;
      miss_cnt_o  <= '0;
      just_filled <= 1'b0;
    end else begin
      just_filled <= (state == READMISSOK);
      if ((state == IDLE) && hit && !just_filled && (hit_cnt_o != '1))
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if ((state == IDLE) && active && !hit && (miss_cnt_o != '1))
        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: miss/refill, hits, dirty writeback, stray ack, reset mid-refill.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         rd;
  logic         wr;
  logic [31:0]  pdata;
  logic         stall;
  logic [31:0]  maddr;
  logic [255:0] mdata_o;
  logic         men;
  logic         mwe;
  logic [255:0] mdata_i;
  logic         ack;
  logic [255:0] line;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .p1_addr_i     (addr),
    .p1_data_i     (wdata),
    .p1_MemRead_i  (rd),
    .p1_MemWrite_i (wr),
    .p1_data_o     (pdata),
    .p1_stall_o    (stall),
    .mem_addr_o    (maddr),
    .mem_data_o    (mdata_o),
    .mem_enable_o  (men),
    .mem_write_o   (mwe),
    .mem_data_i    (mdata_i),
    .mem_ack_i     (ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o     (hit_cnt),
    .miss_cnt_o    (miss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    rst = 1'b0; addr = '0; wdata = '0; rd = 1'b0; wr = 1'b0; mdata_i = '0; ack = 1'b0;
    #3;
    check("rst_stall", stall, 0);
    check("rst_en", men, 0);
    check("rst_we", mwe, 0);
    check("rst_addr", maddr, 0);
    check("rst_pdata", pdata, 0);
    @(negedge clk); rst = 1'b1;

    // Cold load miss and refill
    @(negedge clk); addr = 32'h0000_0404; rd = 1'b1;
    #1 check("miss_stall", stall, 1);
    @(negedge clk); #1 check("miss_en", men, 0);
    @(negedge clk); #1;
    check("rm_en", men, 1);
    check("rm_we", mwe, 0);
    check("rm_addr", maddr, 32'h0000_0400);
    line = '0; line[63:32] = 32'hDEAD_BEEF; mdata_i = line; ack = 1'b1;
    @(negedge clk); ack = 1'b0; mdata_i = '0; #1;
    check("ok_stall", stall, 1);
    check("ok_en", men, 0);
    check("ok_data", pdata, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    check("rel_stall", stall, 0);
    check("rel_data", pdata, 32'hDEAD_BEEF);

    // Repeat load hits
    @(negedge clk); #1;
    check("hit_stall", stall, 0);
    check("hit_data", pdata, 32'hDEAD_BEEF);

    // Store hit, then conflicting load forces dirty writeback
    @(negedge clk); rd = 1'b0; wr = 1'b1; addr = 32'h0000_0408; wdata = 32'h1234_5678;
    #1 check("st_stall", stall, 0);
    @(negedge clk); wr = 1'b0; rd = 1'b1; addr = 32'h0000_0C08;
    #1 check("cf_stall", stall, 1);
    @(negedge clk); #1 check("cf_miss_en", men, 0);
    @(negedge clk); #1;
    check("wb_en", men, 1);
    check("wb_we", mwe, 1);
    check("wb_addr", maddr, 32'h0000_0400);
    check("wb_w2", mdata_o[95:64], 32'h1234_5678);
    check("wb_w1", mdata_o[63:32], 32'hDEAD_BEEF);
    ack = 1'b1;
    @(negedge clk); ack = 1'b0; #1;
    check("rm2_en", men, 1);
    check("rm2_we", mwe, 0);
    check("rm2_addr", maddr, 32'h0000_0C00);
    line = '0; line[95:64] = 32'hCAFE_F00D; mdata_i = line; ack = 1'b1;
    @(negedge clk); ack = 1'b0; mdata_i = '0; #1;
    check("ok2_stall", stall, 1);
    check("ok2_data", pdata, 32'hCAFE_F00D);
    @(negedge clk); #1 check("rel2_stall", stall, 0);
`ifdef DCACHE_STATS_EN
    check("hit_cnt", hit_cnt, 2);
    check("miss_cnt", miss_cnt, 2);
`endif

    // Stray ack while idle must be ignored
    @(negedge clk); rd = 1'b0; addr = '0; mdata_i = '1; ack = 1'b1;
    #1 check("stray_en", men, 0);
    @(negedge clk); ack = 1'b0; mdata_i = '0; rd = 1'b1; addr = 32'h0000_0C08;
    #1;
    check("stray_stall", stall, 0);
    check("stray_data", pdata, 32'hCAFE_F00D);

    // Reset during refill abandons it
    @(negedge clk); addr = 32'h0000_0404;
    #1 check("rr_stall", stall, 1);
    @(negedge clk);
    @(negedge clk); #1;
    check("rr_en", men, 1);
    check("rr_addr", maddr, 32'h0000_0400);
    #1 rst = 1'b0;
    #1;
    check("rr_rst_en", men, 0);
    check("rr_rst_addr", maddr, 0);
    check("rr_rst_stall", stall, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1 check("rl_miss_en", men, 0);
    @(negedge clk); #1;
    check("rl_en", men, 1);
    check("rl_addr", maddr, 32'h0000_0400);
    line = '0; line[63:32] = 32'hDEAD_BEEF; mdata_i = line; ack = 1'b1;
    @(negedge clk); ack = 1'b0; mdata_i = '0;
    @(negedge clk); #1;
    check("rl_stall", stall, 0);
    check("rl_data", pdata, 32'hDEAD_BEEF);

    // Byte offset bits ignored; read+write together acts as a store
    @(negedge clk); addr = 32'h0000_0407;
    #1 check("lo_data", pdata, 32'hDEAD_BEEF);
    @(negedge clk); wr = 1'b1; addr = 32'h0000_0404; wdata = 32'h55AA_55AA;
    #1 check("both_stall", stall, 0);
    @(negedge clk); wr = 1'b0;
    #1 check("both_data", pdata, 32'h55AA_55AA);
    @(negedge clk); rd = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
